// File: rtl/ddr_channel_arb.sv
// Single-channel DDR arbiter: instruction fetch (multi-beat line burst) vs. LSU (single beat).
// One DDR command is outstanding at a time; ties alternate between the two requesters.
module ddr_channel_arb #(
    parameter int IF_BEATS = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     pc_index_valid,
    input  logic [18:0]              pc_index,
    output logic                     pc_index_ready,
    input  logic                     cancel_pc_fetch,
    output logic                     pc_operation_done,
    output logic [64*IF_BEATS-1:0]   pc_read_inst,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [18:0]              lsu_index,
    input  logic                     lsu_write_enable,
    input  logic [63:0]              lsu_write_data,
    input  logic [63:0]              lsu_write_mask,
    output logic                     lsu_operation_done,
    output logic [63:0]              lsu_read_data,
    output logic                     ddr_chip_enable,
    output logic [18:0]              ddr_index,
    output logic                     ddr_write_enable,
    output logic [63:0]              ddr_write_data,
    output logic [63:0]              ddr_write_mask,
    input  logic                     ddr_ready,
    input  logic                     ddr_operation_done,
    input  logic [63:0]              ddr_read_data
);
    localparam int KW = (IF_BEATS > 1) ? $clog2(IF_BEATS) : 1;
    localparam int LW = 64 * IF_BEATS;

    typedef enum logic [2:0] {IDLE, IF_ISSUE, IF_WAIT, LS_ISSUE, LS_WAIT} state_t;

    state_t          state_q, state_d;
    logic            last_lsu_q, last_lsu_d;
    logic [18:0]     base_q, base_d;
    logic [KW-1:0]   k_q, k_d;
    logic            abort_q, abort_d;
    logic [LW-1:0]   shadow_q, shadow_d;
    logic [LW-1:0]   line_q, line_d;
    logic            pc_done_q, pc_done_d;
    logic            lsu_done_q, lsu_done_d;
    logic [63:0]     lsu_rdata_q, lsu_rdata_d;
    logic [18:0]     ls_index_q, ls_index_d;
    logic            ls_we_q, ls_we_d;
    logic [63:0]     ls_wdata_q, ls_wdata_d;
    logic [63:0]     ls_wmask_q, ls_wmask_d;

    assign pc_read_inst       = line_q;
    assign pc_operation_done  = pc_done_q;
    assign lsu_operation_done = lsu_done_q;
    assign lsu_read_data      = lsu_rdata_q;

    always_comb begin
        state_d          = state_q;
        last_lsu_d       = last_lsu_q;
        base_d           = base_q;
        k_d              = k_q;
        abort_d          = abort_q;
        shadow_d         = shadow_q;
        line_d           = line_q;
        pc_done_d        = 1'b0;
        lsu_done_d       = 1'b0;
        lsu_rdata_d      = lsu_rdata_q;
        ls_index_d       = ls_index_q;
        ls_we_d          = ls_we_q;
        ls_wdata_d       = ls_wdata_q;
        ls_wmask_d       = ls_wmask_q;
        pc_index_ready   = 1'b0;
        lsu_ready        = 1'b0;
        ddr_chip_enable  = 1'b0;
        ddr_index        = 19'd0;
        ddr_write_enable = 1'b0;
        ddr_write_data   = 64'd0;
        ddr_write_mask   = 64'd0;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                // On a tie the requester that did not win last time gets the grant.
                if (pc_index_valid && (!lsu_valid || last_lsu_q)) begin
                    pc_index_ready = 1'b1;
                end else if (lsu_valid) begin
                    lsu_ready = 1'b1;
                end
                if (pc_index_ready) begin
                    base_d     = pc_index;
                    k_d        = '0;
                    last_lsu_d = 1'b0;
                    state_d    = IF_ISSUE;
                end else if (lsu_ready) begin
                    ls_index_d = lsu_index;
                    ls_we_d    = lsu_write_enable;
                    ls_wdata_d = lsu_write_data;
                    ls_wmask_d = lsu_write_mask;
                    last_lsu_d = 1'b1;
                    state_d    = LS_ISSUE;
                end
            end
            IF_ISSUE: begin
                if (cancel_pc_fetch) begin
                    state_d = IDLE;
                end else begin
                    ddr_chip_enable = ddr_ready;
                    ddr_index       = base_q + 19'(k_q);
                    if (ddr_ready) state_d = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (cancel_pc_fetch) abort_d = 1'b1;
                if (ddr_operation_done) begin
                    shadow_d[64*k_q +: 64] = ddr_read_data;
                    // An aborted burst drops its partial line; the visible line stays untouched.
                    if (abort_q || cancel_pc_fetch) begin
                        state_d = IDLE;
                    end else if (k_q == KW'(IF_BEATS - 1)) begin
                        line_d    = shadow_d;
                        pc_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = IF_ISSUE;
                    end
                end
            end
            LS_ISSUE: begin
                ddr_chip_enable = ddr_ready;
                ddr_index       = ls_index_q;
                if (ddr_ready) begin
                    ddr_write_enable = ls_we_q;
                    ddr_write_data   = ls_wdata_q;
                    ddr_write_mask   = ls_wmask_q;
                    state_d          = LS_WAIT;
                end
            end
            LS_WAIT: begin
                if (ddr_operation_done) begin
                    lsu_rdata_d = ddr_read_data;
                    lsu_done_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_lsu_q  <= 1'b1;
            base_q      <= '0;
            k_q         <= '0;
            abort_q     <= 1'b0;
            shadow_q    <= '0;
            line_q      <= '0;
            pc_done_q   <= 1'b0;
            lsu_done_q  <= 1'b0;
            lsu_rdata_q <= '0;
            ls_index_q  <= '0;
            ls_we_q     <= 1'b0;
            ls_wdata_q  <= '0;
            ls_wmask_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            base_q      <= base_d;
            k_q         <= k_d;
            abort_q     <= abort_d;
            shadow_q    <= shadow_d;
            line_q      <= line_d;
            pc_done_q   <= pc_done_d;
            lsu_done_q  <= lsu_done_d;
            lsu_rdata_q <= lsu_rdata_d;
            ls_index_q  <= ls_index_d;
            ls_we_q     <= ls_we_d;
            ls_wdata_q  <= ls_wdata_d;
            ls_wmask_q  <= ls_wmask_d;
        end
    end

endmodule

// File: doc/ddr_channel_arb.md
# ddr_channel_arb

Arbitrates the single DDR channel between the instruction-fetch requester (pc_ctrl) and the load/store unit (LSU). Fetch requests are expanded into an IF_BEATS-beat sequential read burst and assembled into one 512-bit instruction line; LSU requests are single 64-bit read or masked write beats. Exactly one DDR transaction is outstanding at any time. The block sits between the frontend/LSU and the DDR controller.

## Interface
- IF_BEATS, 8: 64-bit beats per fetch line; pc_read_inst width is 64*IF_BEATS.
- clock  in  1  Clock (posedge).
- reset_n  in  1  Reset, asynchronous, active-low.
- pc_index_valid  in  1  Fetch request valid; held until accepted.
- pc_index  in  19  Fetch start word index (8-byte units).
- pc_index_ready  out  1  Fetch request accepted when high with pc_index_valid.
- cancel_pc_fetch  in  1  Level. Aborts the fetch burst in progress.
- pc_operation_done  out  1  One-cycle pulse: fetch line complete.
- pc_read_inst  out  512  Assembled line; beat k sits in bits [64k+63:64k].
- lsu_valid  in  1  LSU request valid; held until accepted.
- lsu_ready  out  1  LSU request accepted when high with lsu_valid.
- lsu_index  in  19  LSU word index.
- lsu_write_enable  in  1  1 = write, 0 = read.
- lsu_write_data  in  64  Write data.
- lsu_write_mask  in  64  Per-bit write mask.
- lsu_operation_done  out  1  One-cycle pulse: LSU beat complete.
- lsu_read_data  out  64  Read data; valid with lsu_operation_done.
- ddr_chip_enable  out  1  One-cycle DDR command strobe.
- ddr_index  out  19  DDR word index.
- ddr_write_enable  out  1  DDR write select.
- ddr_write_data  out  64  DDR write data.
- ddr_write_mask  out  64  DDR write mask.
- ddr_ready  in  1  DDR can accept a command this cycle.
- ddr_operation_done  in  1  One-cycle pulse: command complete.
- ddr_read_data  in  64  Read data; valid with ddr_operation_done.

## Operation
- States: IDLE, IF_ISSUE, IF_WAIT, LS_ISSUE, LS_WAIT.
- IDLE: pc_index_ready and lsu_ready are combinational. Only one is high, and only in IDLE. With a single requester, that requester gets ready. With both valid, the requester not granted last gets ready. last_grant resets to LSU, so fetch wins the first tie. last_grant updates on every handshake.
- Fetch handshake: capture pc_index into base and clear beat counter k. Go to IF_ISSUE.
- IF_ISSUE: drive ddr_index = base + k (19-bit wrap, no alignment), ddr_write_enable = 0. ddr_chip_enable = ddr_ready, combinational. When ddr_ready is high, go to IF_WAIT; otherwise hold.
- IF_WAIT: on ddr_operation_done, write ddr_read_data into line slot k.
  - If k = IF_BEATS-1: pulse pc_operation_done the next cycle and go to IDLE.
  - Otherwise: k+1, go to IF_ISSUE.
- Cancel: cancel_pc_fetch high in IF_ISSUE goes straight to IDLE with no command issued. High in IF_WAIT sets an abort flag; the in-flight beat finishes, then go to IDLE. On cancel there is no pc_operation_done and pc_read_inst keeps its previous contents; partial beats are discarded. The abort flag clears in IDLE. Cancel is ignored in IDLE and in the LS states.
- pc_read_inst holds the last completed line until the next completed line replaces it. Lines are assembled in a shadow buffer and copied on completion.
- LSU handshake: capture index, write_enable, data and mask. Go to LS_ISSUE, which issues like IF_ISSUE with the captured fields.
- LS_WAIT: on ddr_operation_done, capture ddr_read_data, pulse lsu_operation_done the next cycle, and go to IDLE. Writes also complete this way; lsu_read_data on a write is don't-care.
- ddr_operation_done in IDLE or an ISSUE state is ignored.
- ddr_write_* drive 0 whenever ddr_chip_enable is low.

## Timing
- Reset values:
  - State IDLE, last_grant = LSU.
  - pc_operation_done, lsu_operation_done, ddr_chip_enable, ddr_write_enable = 0.
  - ddr_index, ddr_write_data, ddr_write_mask, pc_read_inst, lsu_read_data = 0.
- Reset mid-burst returns to IDLE immediately; a later stray ddr_operation_done is ignored.
- Fetch timing, with ddr_ready = 1 and done one cycle after each strobe:
  - Handshake at T.
  - Strobe for beat k at T+1+2k, done at T+2+2k.
  - pc_operation_done at T+2·IF_BEATS+1 (T+17 for 8 beats).
- LSU timing: handshake at T, strobe at T+1, done at T+2, lsu_operation_done at T+3.
- The next handshake is possible in the same cycle the done pulse is driven, because state is already IDLE.
- ddr_ready low stretches the ISSUE state one cycle per low cycle.

## Test plan
- Fetch only: pc_index = 0x00010, DDR returns data = index → strobes at indices 0x10..0x17, pc_read_inst slot k = 0x10+k, single pc_operation_done at T+17.
- Simultaneous requests at reset, both held → fetch granted first, then LSU, then fetch again (alternation); no overlapping ddr_chip_enable.
- LSU write: index 0x7FFFF, data 0xDEADBEEF, mask all-ones, ddr_ready low for 3 cycles → strobe delayed 3 cycles, ddr_write_enable = 1 with the strobe, lsu_operation_done 2 cycles after the strobe.
- Cancel during beat 3 IF_WAIT → beat 3 completes, no beat 4 strobe, no pc_operation_done, pc_read_inst unchanged. A following fetch at 0x40 completes normally.
- Wrap: pc_index = 0x7FFFC → beat indices 0x7FFFC..0x7FFFF, 0x00000..0x00003.
- reset_n low during fetch beat 5 → all outputs 0 asynchronously; a later stray ddr_operation_done is ignored; a fresh fetch works.
